// File: rtl/gpu_sd_write_buffer.sv
// Write buffer between the rasterizer SDRAM write master and the SDRAM controller
// Avalon-MM slave. It captures writes, applies the front/back buffer offset, and replays them in order.
module gpu_sd_write_buffer #(
  parameter int                 DEPTH     = 16,
  parameter int                 ADDR_W    = 22,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  FB_OFFSET = 22'h025800,
  parameter int                 AF_LEVEL  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     SD_write,
  input  logic [ADDR_W-1:0]        SD_address,
  input  logic [DATA_W-1:0]        SD_wdata,
  output logic                     SD_waitrequest,
  input  logic                     buf_sel,
  output logic                     avm_write,
  output logic [ADDR_W-1:0]        avm_address,
  output logic [DATA_W-1:0]        avm_writedata,
  input  logic                     avm_waitrequest,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic [15:0]              write_count,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Address arithmetic is deliberately modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] addr,
                                                input logic             sel);
    fb_addr = addr + (sel ? FB_OFFSET : '0);
  endfunction

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [LVL_W-1:0]  level_nxt;

  // The registered stall bit gates the push, so there is no path from SD_write to SD_waitrequest.
  assign push      = SD_write && !SD_waitrequest;
  assign avm_write = (level != '0);
  assign pop       = avm_write && !avm_waitrequest;

  always_comb begin
    level_nxt = level + LVL_W'(push) - LVL_W'(pop);
  end

  assign avm_address   = avm_write ? addr_mem[rd_ptr] : '0;
  assign avm_writedata = avm_write ? data_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= fb_addr(SD_address, buf_sel);
      data_mem[wr_ptr] <= SD_wdata;
    end
  end

  // Status outputs are registered from the next-state level so they match the post-edge occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      write_count    <= '0;
      SD_waitrequest <= 1'b0;
      almost_full    <= 1'b0;
      idle           <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        write_count <= write_count + 16'd1;
      end
      level          <= level_nxt;
      SD_waitrequest <= (level_nxt == LVL_W'(DEPTH));
      almost_full    <= (level_nxt >= LVL_W'(AF_LEVEL));
      idle           <= (level_nxt == '0);
    end
  end

endmodule

// File: tb/tb_gpu_sd_write_buffer.sv
// Bench for gpu_sd_write_buffer: directed steps plus random traffic, all checked
// against a queue-based model of the buffer.
module tb_gpu_sd_write_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int OFFS   = 'h025800;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              SD_write = 1'b0;
  logic [ADDR_W-1:0] SD_address = '0;
  logic [DATA_W-1:0] SD_wdata = '0;
  logic              SD_waitrequest;
  logic              buf_sel = 1'b0;
  logic              avm_write;
  logic [ADDR_W-1:0] avm_address;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest = 1'b0;
  logic [4:0]        level;
  logic              almost_full;
  logic [15:0]       write_count;
  logic              idle;

  gpu_sd_write_buffer dut (
    .clk(clk), .reset(reset),
    .SD_write(SD_write), .SD_address(SD_address), .SD_wdata(SD_wdata),
    .SD_waitrequest(SD_waitrequest), .buf_sel(buf_sel),
    .avm_write(avm_write), .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .level(level), .almost_full(almost_full), .write_count(write_count), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] rx[$];
  int          wc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          last_push;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, "_level"}, 64'(level), 64'(n));
    chk({tag, "_avm_write"}, 64'(avm_write), 64'(n != 0));
    chk({tag, "_avm_address"}, 64'(avm_address), (n != 0) ? 64'(mq[0].a) : 64'd0);
    chk({tag, "_avm_writedata"}, 64'(avm_writedata), (n != 0) ? 64'(mq[0].d) : 64'd0);
    chk({tag, "_waitreq"}, 64'(SD_waitrequest), 64'(n == DEPTH));
    chk({tag, "_almost_full"}, 64'(almost_full), 64'(n >= 12));
    chk({tag, "_idle"}, 64'(idle), 64'(n == 0));
    chk({tag, "_write_count"}, 64'(write_count), 64'(wc % 65536));
  endtask

  // One clock: model decides push/pop from its own occupancy and the inputs seen before the edge.
  task automatic step(input string tag);
    bit   push, pop;
    ent_t e;
    push = SD_write && (mq.size() != DEPTH);
    pop  = (mq.size() != 0) && !avm_waitrequest;
    e.a  = ADDR_W'((int'(SD_address) + (buf_sel ? OFFS : 0)) % (1 << ADDR_W));
    e.d  = SD_wdata;
    @(posedge clk);
    if (pop) begin
      rx.push_back(mq[0].d);
      void'(mq.pop_front());
      wc++;
    end
    if (push) mq.push_back(e);
    last_push = push;
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    SD_write = 1'b0;
    #1;
    mq.delete();
    rx.delete();
    wc = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_model("reset");
  endtask

  initial begin
    int idx;
    int guard;

    // Reset and single pass-through write
    do_reset();
    chk("reset_idle", 64'(idle), 64'd1);
    SD_write = 1'b1; SD_address = 22'd100; SD_wdata = 32'h00FF00FF; buf_sel = 1'b0;
    avm_waitrequest = 1'b0;
    step("single");
    SD_write = 1'b0;
    chk("pass_write", 64'(avm_write), 64'd1);
    chk("pass_addr", 64'(avm_address), 64'd100);
    chk("pass_data", 64'(avm_writedata), 64'h00FF00FF);
    step("single_pop");
    chk("pass_idle", 64'(idle), 64'd1);
    chk("pass_count", 64'(write_count), 64'd1);

    // Back-buffer offset and offset wrap
    avm_waitrequest = 1'b1;
    SD_write = 1'b1; buf_sel = 1'b1; SD_address = 22'h000010; SD_wdata = 32'hA5A5_0001;
    step("offset");
    SD_address = 22'h3FFFFF; SD_wdata = 32'hA5A5_0002;
    step("offset_wrap");
    SD_write = 1'b0; buf_sel = 1'b0;
    chk("offset_addr", 64'(avm_address), 64'h025810);
    avm_waitrequest = 1'b0;
    step("offset_pop");
    chk("offset_wrap_addr", 64'(avm_address), 64'h0257FF);
    step("offset_drain");

    // Fill to full with the downstream stalled, GPU holding its request
    do_reset();
    avm_waitrequest = 1'b1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      SD_write = (idx < 20); SD_wdata = 32'(idx); SD_address = 22'(200 + idx);
      step("fill");
      if (last_push) idx++;
      if (idx == 12) chk("af_at_12", 64'(almost_full), 64'd1);
      chk("fill_head_data", 64'(avm_writedata), 64'd0);
    end
    chk("full_level", 64'(level), 64'd16);
    chk("full_waitreq", 64'(SD_waitrequest), 64'd1);
    chk("full_pushed", 64'(idx), 64'd16);

    // Drain from full while the GPU resumes
    avm_waitrequest = 1'b0;
    guard = 0;
    while ((idx < 20 || mq.size() != 0) && guard < 100) begin
      SD_write = (idx < 20); SD_wdata = 32'(idx); SD_address = 22'(200 + idx);
      step("drain");
      if (last_push) idx++;
      guard++;
    end
    SD_write = 1'b0;
    chk("drain_bounded", 64'(guard < 100), 64'd1);
    chk("drain_rx_count", 64'(rx.size()), 64'd20);
    for (int i = 0; i < rx.size() && i < 20; i++) chk("drain_order", 64'(rx[i]), 64'(i));
    chk("drain_count", 64'(write_count), 64'd20);
    chk("drain_idle", 64'(idle), 64'd1);

    // Simultaneous push/pop at level 5
    avm_waitrequest = 1'b1;
    SD_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      SD_wdata = 32'h1000 + 32'(i); SD_address = 22'(i);
      step("sim_fill");
    end
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 10; i++) begin
      SD_wdata = 32'h2000 + 32'(i); SD_address = 22'(50 + i);
      step("sim_both");
    end
    chk("sim_level", 64'(level), 64'd5);
    chk("sim_count", 64'(write_count), 64'd30);
    SD_write = 1'b0;

    // Reset mid-burst with level 9 and the downstream stalled
    do_reset();
    avm_waitrequest = 1'b1;
    SD_write = 1'b1;
    for (int i = 0; i < 9; i++) begin
      SD_wdata = 32'hDEAD_0000 + 32'(i); SD_address = 22'(300 + i);
      step("mid_fill");
    end
    SD_write = 1'b0;
    chk("mid_level9", 64'(level), 64'd9);
    reset = 1'b0;
    #1;
    chk("mid_rst_avm_write", 64'(avm_write), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_count", 64'(write_count), 64'd0);
    mq.delete(); rx.delete(); wc = 0;
    @(negedge clk);
    reset = 1'b1;
    avm_waitrequest = 1'b0;
    SD_write = 1'b1; SD_wdata = 32'hCAFE_F00D; SD_address = 22'd77;
    step("post_rst");
    SD_write = 1'b0;
    chk("post_rst_data", 64'(avm_writedata), 64'hCAFE_F00D);
    chk("post_rst_addr", 64'(avm_address), 64'd77);
    step("post_rst_pop");
    chk("post_rst_idle", 64'(idle), 64'd1);

    // Random traffic: stall-heavy first half, then light stalls
    for (int c = 0; c < 600; c++) begin
      SD_write        = ($urandom_range(0, 3) != 0);
      buf_sel         = 1'($urandom);
      SD_address      = ADDR_W'($urandom);
      SD_wdata        = $urandom;
      avm_waitrequest = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step("rand");
    end
    SD_write = 1'b0;
    avm_waitrequest = 1'b0;
    for (int c = 0; c < 20; c++) step("rand_drain");
    chk("rand_idle", 64'(idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_sd_write_buffer.md
Name: gpu_sd_write_buffer

Overview:
- Sits directly downstream of the GPU rasterizer, on its SDRAM write master (SD_write / SD_wdata / SD_address / SD_waitrequest).
- Absorbs bursts of pixel writes in a FIFO and replays them to the SDRAM controller's Avalon-MM write slave.
- Decouples rasterizer stalls from SDRAM refresh and arbitration latency.
- Adds a double-buffer offset to each address at capture, and reports occupancy, completed-write count and idle status.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 22, SDRAM word-address width.
- DATA_W, 32, pixel data width.
- FB_OFFSET, 22'h025800, word offset added to addresses when the back buffer is selected.
- AF_LEVEL, 12, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- SD_write  in  1  write request from GPU
- SD_address  in  ADDR_W  pixel word address from GPU
- SD_wdata  in  DATA_W  pixel data from GPU
- SD_waitrequest  out  1  stall to GPU
- buf_sel  in  1  0 = front buffer, 1 = back buffer; sampled per accepted write
- avm_write  out  1  write request to SDRAM controller
- avm_address  out  ADDR_W  SDRAM word address
- avm_writedata  out  DATA_W  SDRAM write data
- avm_waitrequest  in  1  stall from SDRAM controller
- level  out  $clog2(DEPTH)+1  current occupancy
- almost_full  out  1  level >= AF_LEVEL
- write_count  out  16  completed downstream writes, wraps
- idle  out  1  FIFO empty

Behaviour:
- Reset (reset = 0, asynchronous), all outputs at reset:
  - pointers and level = 0
  - write_count = 0
  - avm_write = 0, avm_address = 0, avm_writedata = 0
  - SD_waitrequest = 0, almost_full = 0, idle = 1
  - Storage contents are not reset.
- Upstream push:
  - A push occurs on a rising edge where SD_write = 1 and SD_waitrequest = 0.
  - Stored entry = {SD_address + (buf_sel ? FB_OFFSET : 0) truncated to ADDR_W, SD_wdata}. buf_sel is sampled on the same edge as the push.
  - SD_waitrequest = (level == DEPTH), driven from a register, no combinational path from SD_write.
  - SD_write while full causes no push and no change in state; the GPU holds its request.
- Downstream pop:
  - avm_write = (level != 0).
  - avm_address and avm_writedata = head entry while avm_write = 1, otherwise 0.
  - A pop occurs on a rising edge where avm_write = 1 and avm_waitrequest = 0.
  - On pop: head advances and write_count increments, modulo 2^16.
  - While avm_waitrequest = 1, avm_address and avm_writedata stay stable.
- Latency: a write pushed into an empty FIFO at edge N is presented on avm_* during the cycle after edge N. Minimum pass-through is 1 cycle.
- Throughput: one push and one pop per cycle. On a simultaneous push and pop, level is unchanged.
- Full with simultaneous pop: SD_waitrequest is already 1, so no push that cycle. Level becomes DEPTH-1 and SD_waitrequest drops on the following cycle.
- Empty: no pop is possible; avm_write stays low.
- Pointers: width $clog2(DEPTH), wrap naturally.
- Status outputs: level, almost_full and idle are registered and consistent with the post-edge state.
- Reset mid-operation: all buffered writes are discarded. avm_write drops immediately (asynchronous), with no partial transaction held.
- No other states. Control is FIFO occupancy only: EMPTY (idle), PARTIAL, FULL (SD_waitrequest high).

Test Plan:
- Single write, pass-through: reset, buf_sel = 0, one write SD_address = 100, SD_wdata = 32'h00FF00FF, avm_waitrequest = 0.
  - Next cycle: avm_write = 1, avm_address = 100, avm_writedata = 32'h00FF00FF.
  - Following cycle: idle = 1, write_count = 1.
- Back-buffer offset: buf_sel = 1, SD_address = 22'h000010 -> avm_address = 22'h025810.
  - Offset wrap: SD_address = 22'h3FFFFF with buf_sel = 1 -> avm_address = 22'h0257FF.
- Fill to full: avm_waitrequest = 1, 20 back-to-back writes with data 0..19.
  - SD_waitrequest = 1 after 16 pushes; level = 16.
  - almost_full = 1 from level 12.
  - avm_address/avm_writedata stay on entry 0.
- Drain in order: release avm_waitrequest from the full state.
  - Data is received strictly as 0..19 with no loss or duplication; the GPU resumes once SD_waitrequest drops.
  - write_count = 20; idle = 1 at the end.
- Simultaneous push/pop: level = 5 and both sides active for 10 cycles -> level stays 5, write_count advances by 10.
- Reset mid-burst: assert reset with level = 9 and avm_waitrequest = 1.
  - Same time: avm_write = 0, level = 0, write_count = 0.
  - After release, the first new write appears with its own data, no stale entries.
